// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with start-bit validation, framing-error
// detection and break hold-off until the line returns high.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ce_16,
    input  logic                 ser_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 new_rx_data,
    output logic                 framing_error,
    output logic                 rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [3:0]           cnt16;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= ser_in;
            rx_s <= rx_m;
        end
    end
    // Start is confirmed at tick 7 (mid start bit); data and stop are then sampled every 16 ticks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt16         <= 4'd0;
            bit_cnt       <= 4'd0;
            shreg         <= '0;
            rx_data       <= '0;
            new_rx_data   <= 1'b0;
            framing_error <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            new_rx_data   <= 1'b0;
            framing_error <= 1'b0;
            if (ce_16) begin
                case (state)
                    IDLE: begin
                        cnt16 <= 4'd0;
                        if (!rx_s) begin
                            state   <= START;
                            cnt16   <= 4'd1;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        cnt16 <= cnt16 + 4'd1;
                        if (cnt16 == 4'd7) begin
                            cnt16   <= 4'd0;
                            bit_cnt <= 4'd0;
                            state   <= rx_s ? IDLE : DATA;
                            rx_busy <= !rx_s;
                        end
                    end
                    DATA: begin
                        cnt16 <= cnt16 + 4'd1;
                        if (cnt16 == 4'd15) begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT) state <= STOP;
                        end
                    end
                    STOP: begin
                        cnt16 <= cnt16 + 4'd1;
                        if (cnt16 == 4'd15) begin
                            if (rx_s) begin
                                rx_data     <= shreg;
                                new_rx_data <= 1'b1;
                                state       <= IDLE;
                                rx_busy     <= 1'b0;
                            end else begin
                                framing_error <= 1'b1;
                                state         <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        cnt16 <= 4'd0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tests for uart_rx with inline checks.
module tb_uart_rx;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_16 = 1'b0;
    logic       ser_in = 1'b1;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       framing_error;
    logic       rx_busy;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ce_per = 1;
    int         cyc = 0;
    int         nrx = 0;
    int         nfe = 0;
    int         nboth = 0;
    int         nfrozen = 0;
    logic [7:0] data_log [8];
    int         time_log [8];
    logic       ce_at_edge = 1'b0;
    logic       busy_prev = 1'b0;
    logic       new_prev = 1'b0;

    uart_rx #(.DATA_BITS(8)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ce_16(ce_16),
        .ser_in(ser_in),
        .rx_data(rx_data),
        .new_rx_data(new_rx_data),
        .framing_error(framing_error),
        .rx_busy(rx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc        <= cyc + 1;
        ce_at_edge <= ce_16;
    end

    initial begin : ce_gen
        int k;
        k = 0;
        forever begin
            @(negedge clock);
            k = (k + 1 >= ce_per) ? 0 : k + 1;
            ce_16 = (k == 0);
        end
    end

    // Event monitor: counts pulse cycles and flags any output change after a non-ce_16 edge.
    always @(negedge clock) begin
        if (new_rx_data) begin
            if (nrx < 8) begin
                data_log[nrx[2:0]] = rx_data;
                time_log[nrx[2:0]] = cyc;
            end
            nrx++;
        end
        if (framing_error) nfe++;
        if (new_rx_data && framing_error) nboth++;
        if (!ce_at_edge && ((rx_busy !== busy_prev) || (new_rx_data && !new_prev))) nfrozen++;
        busy_prev = rx_busy;
        new_prev  = new_rx_data;
    end

    task automatic wait_ticks(input int n);
        repeat (n * ce_per) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        ser_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            ser_in = d[i];
            wait_ticks(16);
        end
        ser_in = stop;
        wait_ticks(16);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ser_in  = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (new_rx_data !== 1'b0) begin n_fail++; $display("FAIL reset_new_rx_data: got %b expected 0", new_rx_data); end
        n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        reset_n = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_basic_frame();
        int b = nrx;
        int f = nfe;
        send_frame(8'h55, 1'b1);
        ser_in = 1'b1;
        wait_ticks(20);
        n_checks++; if (nrx - b !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 1", nrx - b); end
        n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h expected 55", rx_data); end
        n_checks++; if (nfe - f !== 0) begin n_fail++; $display("FAIL basic_ferr: got %0d expected 0", nfe - f); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", rx_busy); end
    endtask

    task automatic test_false_start();
        int b = nrx;
        int f = nfe;
        ser_in = 1'b0;
        wait_ticks(4);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_high: got %b expected 1", rx_busy); end
        ser_in = 1'b1;
        wait_ticks(8);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_low: got %b expected 0", rx_busy); end
        n_checks++; if (nrx - b !== 0 || nfe - f !== 0) begin n_fail++; $display("FAIL false_start_pulses: got rx %0d fe %0d expected 0 0", nrx - b, nfe - f); end
        send_frame(8'h3C, 1'b1);
        ser_in = 1'b1;
        wait_ticks(20);
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL false_start_next_data: got %h expected 3c", rx_data); end
        n_checks++; if (nrx - b !== 1) begin n_fail++; $display("FAIL false_start_next_pulses: got %0d expected 1", nrx - b); end
    endtask

    task automatic test_framing_error();
        int b = nrx;
        int f = nfe;
        send_frame(8'hA3, 1'b0);
        wait_ticks(40);
        n_checks++; if (nfe - f !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", nfe - f); end
        n_checks++; if (nrx - b !== 0) begin n_fail++; $display("FAIL ferr_no_rx: got %0d expected 0", nrx - b); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected 3c", rx_data); end
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b expected 1", rx_busy); end
        n_checks++; if (nboth !== 0) begin n_fail++; $display("FAIL ferr_both_pulses: got %0d expected 0", nboth); end
        ser_in = 1'b1;
        wait_ticks(4);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit: got %b expected 0", rx_busy); end
        wait_ticks(20);
    endtask

    task automatic test_back_to_back();
        int b = nrx;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        ser_in = 1'b1;
        wait_ticks(20);
        n_checks++; if (nrx - b !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", nrx - b); end
        n_checks++; if (data_log[b[2:0]] !== 8'h00) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 00", data_log[b[2:0]]); end
        n_checks++; if (data_log[3'(b + 1)] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data: got %h expected ff", data_log[3'(b + 1)]); end
        n_checks++; if (time_log[3'(b + 1)] - time_log[b[2:0]] !== 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 160", time_log[3'(b + 1)] - time_log[b[2:0]]); end
        n_checks++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_final_data: got %h expected ff", rx_data); end
    endtask

    task automatic test_slow_ce();
        int b;
        int f;
        ce_per = 3;
        wait_ticks(4);
        b = nrx;
        f = nfe;
        send_frame(8'h81, 1'b1);
        ser_in = 1'b1;
        wait_ticks(20);
        n_checks++; if (nrx - b !== 1) begin n_fail++; $display("FAIL slow_pulses: got %0d expected 1", nrx - b); end
        n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL slow_data: got %h expected 81", rx_data); end
        n_checks++; if (nfe - f !== 0) begin n_fail++; $display("FAIL slow_ferr: got %0d expected 0", nfe - f); end
        n_checks++; if (nfrozen !== 0) begin n_fail++; $display("FAIL slow_frozen: got %0d changes off ce_16 expected 0", nfrozen); end
    endtask

    task automatic test_reset_midframe();
        int b;
        int f;
        logic [7:0] d;
        ce_per = 1;
        wait_ticks(4);
        b = nrx;
        f = nfe;
        d = 8'h5A;
        ser_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            ser_in = d[i];
            wait_ticks(16);
        end
        ser_in = d[4];
        wait_ticks(8);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", rx_busy); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", rx_busy); end
        n_checks++; if (new_rx_data !== 1'b0 || framing_error !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses: got %b%b expected 00", new_rx_data, framing_error); end
        @(negedge clock);
        ser_in = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_ticks(20);
        n_checks++; if (nrx - b !== 0 || nfe - f !== 0) begin n_fail++; $display("FAIL midreset_no_pulse: got rx %0d fe %0d expected 0 0", nrx - b, nfe - f); end
        send_frame(8'h7E, 1'b1);
        ser_in = 1'b1;
        wait_ticks(20);
        n_checks++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL midreset_next_data: got %h expected 7e", rx_data); end
        n_checks++; if (nrx - b !== 1) begin n_fail++; $display("FAIL midreset_next_pulses: got %0d expected 1", nrx - b); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_false_start();
        test_framing_error();
        test_back_to_back();
        test_slow_ce();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame (legal 5..8).
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port ce_16, input, 1, the single-cycle 16x-baud enable from the baud rate generator.
REQ-005 The block SHALL have port ser_in, input, 1, the asynchronous serial line (idle high).
REQ-006 The block SHALL have port rx_data, output, DATA_BITS, the last correctly framed received word.
REQ-007 The block SHALL have port new_rx_data, output, 1, a one-clock pulse marking an rx_data update.
REQ-008 The block SHALL have port framing_error, output, 1, a one-clock pulse marking a bad stop bit.
REQ-009 The block SHALL have port rx_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL pass ser_in through a 2-flop synchronizer (rx_s), with both flops resetting to 1; only rx_s is sampled.
REQ-011 The block SHALL advance state, the 4-bit tick counter cnt16, the bit counter and the shift register only on cycles with ce_16=1; it SHALL hold all of them otherwise.
REQ-012 The block SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: cnt16 held at 0; on ce_16 with rx_s=0 -> START, cnt16=1.
REQ-014 START: cnt16 increments per tick; on the tick with cnt16=7, rx_s=1 -> IDLE (false start, no output) and rx_s=0 -> DATA with cnt16=0 and bit count 0.
REQ-015 DATA: cnt16 increments per tick and wraps 15->0; on the tick with cnt16=15, rx_s is shifted in LSB-first and the bit count increments; after DATA_BITS bits -> STOP.
REQ-016 STOP: on the tick with cnt16=15, rx_s=1 -> rx_data loads the shift register, new_rx_data pulses and the state -> IDLE.
REQ-017 STOP: on the tick with cnt16=15, rx_s=0 -> framing_error pulses, rx_data is unchanged and the state -> BREAK.
REQ-018 BREAK: the state -> IDLE on the first ce_16 tick with rx_s=1; no start detection occurs while in BREAK.
REQ-019 new_rx_data and framing_error SHALL be registered, asserted for exactly one clock in the cycle after the stop-sample tick, and never asserted together.
REQ-020 There SHALL be no overrun handshake: a new word overwrites rx_data and pulses new_rx_data again.
REQ-021 The block SHALL operate correctly with ce_16 high every clock and with ce_16 at any sparser regular rate.
REQ-022 rx_busy SHALL be registered and equal (state != IDLE).

Reset
REQ-023 While reset_n=0 the block SHALL force the state to IDLE, cnt16, the bit count, the shift register and rx_data to 0, new_rx_data, framing_error and rx_busy to 0, and the synchronizer flops to 1.
REQ-024 A reset asserted mid-frame SHALL abort the frame without any output pulse; after release the next full frame SHALL be received normally.

Verification
REQ-025 ce_16 every clock, frame 0x55 (16 clocks/bit) -> one new_rx_data pulse, rx_data=0x55, framing_error never high.
REQ-026 ser_in low for 4 ticks and then high -> no pulses, rx_busy returns to 0 by tick 8, and a following frame 0x3C is received correctly.
REQ-027 frame 0xA3 with stop bit 0, held low a further 40 ticks -> one framing_error pulse, rx_data keeps the previous value, rx_busy stays high until ser_in returns high.
REQ-028 back-to-back frames 0x00 then 0xFF with no idle gap -> two new_rx_data pulses, 160 ticks apart, with the matching rx_data values.
REQ-029 ce_16 once every 3 clocks, frame 0x81 -> rx_data=0x81, a single new_rx_data pulse, all state frozen on non-ce_16 cycles.
REQ-030 reset_n pulsed low during data bit 4 of a frame -> all outputs 0 immediately, no pulse; the next frame 0x7E -> rx_data=0x7E.
